// File: rtl/saed_dff_pkg.sv
// Shared types and helpers for the saed_dff elastic register pipeline.
package saed_dff_pkg;

  // Fill bit replicated across WIDTH to form the default set value.
  localparam logic SET_VAL_FILL = 1'b1;

  typedef struct packed {
    logic valid;
    logic poison;
  } stage_flags_t;

  function automatic int unsigned occ_width(input int unsigned depth);
    return unsigned'($clog2(depth + 1));
  endfunction

endpackage

// File: rtl/saed_dff_pipe_stage.sv
// One elastic stage: captures on load, empties on drain, and set overwrites whatever
// remains valid with SET_VAL while clearing poison.
module saed_dff_pipe_stage
  import saed_dff_pkg::*;
#(
  parameter int unsigned      WIDTH   = 8,
  parameter logic [WIDTH-1:0] SET_VAL = {WIDTH{SET_VAL_FILL}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set,
  input  logic             load,
  input  logic             drain,
  input  logic [WIDTH-1:0] d_in,
  input  logic             p_in,
  output stage_flags_t     flags,
  output logic [WIDTH-1:0] data
);

  logic next_valid;

  assign next_valid = load | (flags.valid & ~drain);

  // NOTE: non-blocking assignments keep every stage sampling pre-edge values,
  // so the chain shifts by exactly one position per clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: data is reset as well; it is a handful of flops, and a known
      // out_data after reset is part of the interface contract.
      flags <= '0;
      data  <= '0;
    end else begin
      flags.valid <= next_valid;
      if (set) begin
        if (next_valid) begin
          data         <= SET_VAL;
          flags.poison <= 1'b0;
        end
      end else if (load) begin
        data         <= d_in;
        flags.poison <= p_in;
      end
    end
  end

endmodule

// File: rtl/saed_dff_pipe.sv
// WIDTH x DEPTH elastic register pipeline with valid/ready handshaking, bubble
// collapsing, synchronous set, and a poison flag that travels with each datum.
module saed_dff_pipe
  import saed_dff_pkg::*;
#(
  parameter int unsigned      WIDTH   = 8,
  parameter int unsigned      DEPTH   = 2,
  parameter logic [WIDTH-1:0] SET_VAL = {WIDTH{SET_VAL_FILL}},
  parameter int unsigned      CNT_W   = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        set,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH-1:0]            in_data,
  input  logic                        in_ntfr,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WIDTH-1:0]            out_data,
  output logic                        out_poison,
  output logic [occ_width(DEPTH)-1:0] occupancy,
  output logic [CNT_W-1:0]            poison_cnt
);

  localparam int unsigned OCC_W = occ_width(DEPTH);

  stage_flags_t     flags      [DEPTH];
  logic [WIDTH-1:0] data       [DEPTH];
  logic [WIDTH-1:0] stage_d_in [DEPTH];
  logic [DEPTH-1:0] stage_p_in;
  logic [DEPTH-1:0] load;
  logic [DEPTH-1:0] adv;
  logic [DEPTH-1:0] next_valid;
  logic             chain_free;
  logic             in_xfer;
  logic [OCC_W-1:0] occ_next;

  // Ready ripples from out_ready back to the input, so an empty slot anywhere
  // downstream lets the stages behind it move up in the same cycle.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    adv        = '0;
    chain_free = out_ready;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      adv[k]     = flags[k].valid & chain_free;
      chain_free = ~flags[k].valid | adv[k];
    end
    in_ready = ~set & chain_free;
  end

  assign in_xfer = in_valid & in_ready;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign load[k]       = in_xfer;
      assign stage_d_in[k] = in_data;
      assign stage_p_in[k] = in_ntfr;
    end else begin : g_body
      assign load[k]       = adv[k-1];
      assign stage_d_in[k] = data[k-1];
      assign stage_p_in[k] = flags[k-1].poison;
    end

    assign next_valid[k] = load[k] | (flags[k].valid & ~adv[k]);

    saed_dff_pipe_stage #(
      .WIDTH   (WIDTH),
      .SET_VAL (SET_VAL)
    ) u_stage (
      .clk   (clk),
      .rst   (rst),
      .set   (set),
      .load  (load[k]),
      .drain (adv[k]),
      .d_in  (stage_d_in[k]),
      .p_in  (stage_p_in[k]),
      .flags (flags[k]),
      .data  (data[k])
    );
  end

  always_comb begin
    occ_next = '0;
    for (int k = 0; k < DEPTH; k++) begin
      occ_next = occ_next + OCC_W'(next_valid[k]);
    end
  end

  // Occupancy is registered so it never depends on the current cycle's handshakes.
  always_ff @(posedge clk) begin
    if (rst) begin
      occupancy  <= '0;
      poison_cnt <= '0;
    end else begin
      occupancy <= occ_next;
      if (in_xfer && in_ntfr && (poison_cnt != {CNT_W{1'b1}})) begin
        poison_cnt <= poison_cnt + CNT_W'(1);
      end
    end
  end

  assign out_valid  = flags[DEPTH-1].valid;
  assign out_data   = data[DEPTH-1];
  assign out_poison = flags[DEPTH-1].poison;

endmodule

// File: tb/tb_saed_dff_pipe.sv
// Directed bench for saed_dff_pipe: a DEPTH=2/CNT_W=2 instance for handshake, set,
// reset and poison behaviour, plus a DEPTH=4 instance scored against a queue model.
module tb_saed_dff_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, set, in_valid, in_ready, in_ntfr;
  logic       out_valid, out_ready, out_poison;
  logic [7:0] in_data, out_data;
  logic [1:0] occupancy, poison_cnt;

  logic       set4, in_valid4, in_ready4, in_ntfr4;
  logic       out_valid4, out_ready4, out_poison4;
  logic [7:0] in_data4, out_data4, poison_cnt4;
  logic [2:0] occupancy4;

  saed_dff_pipe #(.WIDTH(8), .DEPTH(2), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .set(set),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ntfr(in_ntfr),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_poison(out_poison), .occupancy(occupancy), .poison_cnt(poison_cnt)
  );

  saed_dff_pipe #(.WIDTH(8), .DEPTH(4), .CNT_W(8)) dut4 (
    .clk(clk), .rst(rst), .set(set4),
    .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4), .in_ntfr(in_ntfr4),
    .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4),
    .out_poison(out_poison4), .occupancy(occupancy4), .poison_cnt(poison_cnt4)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [4:0]  pat;
  int          n_poison;
  logic [7:0]  q[$];
  int          sent, recv;
  logic        in_fire, out_fire;
  logic [7:0]  od;
  logic [31:0] exp_d;

  initial begin
    rst = 1'b1; set = 1'b0; in_valid = 1'b0; in_data = '0; in_ntfr = 1'b0; out_ready = 1'b0;
    set4 = 1'b0; in_valid4 = 1'b0; in_data4 = '0; in_ntfr4 = 1'b0; out_ready4 = 1'b0;
    step();
    step();
    rst = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_poison", out_poison, 0);
    check("rst_occupancy", occupancy, 0);
    check("rst_poison_cnt", poison_cnt, 0);
    check("rst_in_ready", in_ready, 1);

    // Stream 0x01..0x05 with out_ready high.
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      in_valid = (i < 5);
      in_data  = 8'(i + 1);
      step();
      if (i == 0) check("t1_latency", out_valid, 0);
      if (i >= 1 && i <= 5) begin
        check("t1_valid", out_valid, 1);
        check("t1_data", out_data, 32'(i));
      end
      if (i >= 1 && i <= 4) check("t1_occ_full", occupancy, 2);
    end
    check("t1_empty_valid", out_valid, 0);
    check("t1_empty_hold", out_data, 8'h05);

    // Fill with out_ready low, then release.
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h11;
    step();
    in_data = 8'h22;
    step();
    in_data = 8'h33;
    step();
    check("t2_occ", occupancy, 2);
    check("t2_in_ready", in_ready, 0);
    check("t2_out_valid", out_valid, 1);
    check("t2_hold", out_data, 8'h11);
    out_ready = 1'b1;
    #1;
    check("t2_ready_chain", in_ready, 1);
    step();
    check("t2_rel1", out_data, 8'h22);
    check("t2_occ_pass", occupancy, 2);
    in_valid = 1'b0;
    step();
    check("t2_rel2", out_data, 8'h33);
    check("t2_occ_drain", occupancy, 1);
    step();
    check("t2_drained", out_valid, 0);

    // Set while a poisoned 0xA5 is stalled in the output stage.
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'hA5; in_ntfr = 1'b1;
    step();
    in_valid = 1'b0; in_ntfr = 1'b0;
    step();
    check("t3_pre_data", out_data, 8'hA5);
    check("t3_pre_poison", out_poison, 1);
    set = 1'b1; in_valid = 1'b1; in_data = 8'h77;
    #1;
    check("t3_set_in_ready", in_ready, 0);
    step();
    set = 1'b0; in_valid = 1'b0;
    check("t3_set_data", out_data, 8'hFF);
    check("t3_set_poison", out_poison, 0);
    check("t3_set_valid", out_valid, 1);
    check("t3_set_occ", occupancy, 1);
    check("t3_cnt_kept", poison_cnt, 1);

    // rst together with set on a full pipeline.
    in_valid = 1'b1; in_data = 8'h44;
    step();
    in_valid = 1'b0;
    check("t4_full", occupancy, 2);
    rst = 1'b1; set = 1'b1; out_ready = 1'b1;
    step();
    rst = 1'b0; set = 1'b0; out_ready = 1'b0;
    #1;
    check("t4_valid", out_valid, 0);
    check("t4_occ", occupancy, 0);
    check("t4_data", out_data, 0);
    check("t4_poison", out_poison, 0);
    check("t4_cnt", poison_cnt, 0);
    check("t4_in_ready", in_ready, 1);

    // Poison tagging: ntfr pattern 1,0,1,0,1, then saturation of the 2-bit counter.
    pat = 5'b10101;
    n_poison = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_valid = (i < 5);
      in_data  = 8'(8'h50 + i);
      in_ntfr  = (i < 5) ? pat[i] : 1'b0;
      step();
      if (i < 5 && pat[i]) n_poison++;
      check("t5_cnt", poison_cnt, (n_poison > 3) ? 3 : n_poison);
      if (i >= 1) begin
        check("t5_data", out_data, 32'(8'h50 + i - 1));
        check("t5_poison", out_poison, 32'(pat[i-1]));
      end
    end
    for (int j = 0; j < 2; j++) begin
      in_valid = 1'b1; in_ntfr = 1'b1; in_data = 8'(8'h60 + j);
      step();
      n_poison++;
      check("t5_sat", poison_cnt, (n_poison > 3) ? 3 : n_poison);
    end
    in_valid = 1'b0; in_ntfr = 1'b0;
    step();
    step();

    // DEPTH=4: sparse input, irregular out_ready, queue scoreboard.
    sent = 0;
    recv = 0;
    for (int c = 0; c < 150 && recv < 12; c++) begin
      in_valid4  = (c % 2 == 0) && (sent < 12);
      in_data4   = 8'(8'h80 + sent);
      out_ready4 = ((c % 7) >= 3) && !(c >= 20 && c < 32);
      @(negedge clk);
      in_fire  = in_valid4 && in_ready4;
      out_fire = out_valid4 && out_ready4;
      od       = out_data4;
      @(posedge clk);
      #1;
      if (out_fire) begin
        exp_d = (q.size() > 0) ? 32'(q.pop_front()) : 32'hDEAD_BEEF;
        check("t6_order", od, exp_d);
        recv++;
      end
      if (in_fire) begin
        q.push_back(in_data4);
        sent++;
      end
      check("t6_occ", occupancy4, q.size());
    end
    check("t6_recv", recv, 12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
